// File: rtl/data_up_pkg.sv
// data_up_pkg: shared FSM state, bus widths and error default for the up-access hub
package data_up_pkg;
  localparam int UP_AW = 32;
  localparam int UP_DW = 32;
  localparam logic [UP_DW-1:0] DEAD_DEF = 32'hDEADBEEF;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
endpackage

// File: rtl/data_up_tmo.sv
// data_up_tmo: 8-bit clear/increment counter with a terminal-count flag at LIM
module data_up_tmo #(
  parameter int LIM = 15
) (
  input  logic up_clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);
  logic [7:0] cnt;
  // Saturating count so a stuck access can never wrap back into range
  always_ff @(posedge up_clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != 8'hFF) cnt <= cnt + 8'd1;
  assign tc = cnt == 8'(LIM);
endmodule

// File: rtl/data_up_hub.sv
// data_up_hub: registered up-bus to channel access hub; DATA_UP_HUB_ACK_EN selects ack/timeout over fixed read latency
module data_up_hub
  import data_up_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int SEL_LSB = 17,
  parameter int SEL_W = 1,
  parameter int TIMEOUT = 16,
  parameter int RD_LAT = 1,
  parameter logic [UP_DW-1:0] DEAD_VAL = DEAD_DEF
) (
  input  logic                  up_clk,
  input  logic                  rst,
  input  logic                  up_wr,
  input  logic                  up_rd,
  input  logic [UP_AW-1:0]      up_addr,
  input  logic [UP_DW-1:0]      up_data_wr,
  output logic [UP_DW-1:0]      up_data_rd,
  output logic                  up_ack,
  output logic                  up_err,
  output logic [N_CH-1:0]       ch_wr,
  output logic [N_CH-1:0]       ch_rd,
  output logic [UP_AW-1:0]      ch_addr,
  output logic [UP_DW-1:0]      ch_data_wr,
  input  logic [N_CH*UP_DW-1:0] ch_data_rd,
  input  logic [N_CH-1:0]       ch_ack
);
`ifdef DATA_UP_HUB_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif
  localparam int LIM = ACK_EN ? TIMEOUT - 1 : RD_LAT;
  state_t state, state_nxt;
  logic wr, err, err_nxt, ld, tc, fin, fail, req, miss;
  logic [SEL_W-1:0] sel, sel_in;
  logic [N_CH-1:0] sel_oh;
  logic [UP_AW-1:0] addr;
  logic [UP_DW-1:0] data, rd_slice;
  assign req = up_wr | up_rd;
  assign sel_in = up_addr[SEL_LSB +: SEL_W];
  assign miss = 32'(sel_in) >= N_CH;
  assign sel_oh = N_CH'(1) << sel;
  assign rd_slice = ch_data_rd[UP_DW*sel +: UP_DW];
`ifdef DATA_UP_HUB_ACK_EN
  assign fin = |(ch_ack & sel_oh);
  assign fail = tc;
`else
  logic unused_ack;
  assign unused_ack = ^ch_ack;
  assign fin = tc;
  assign fail = 1'b0;
`endif
  data_up_tmo #(.LIM(LIM)) u_tmo (
    .up_clk(up_clk),
    .rst(rst),
    .clr(state == IDLE),
    .inc(state == ISSUE || state == WAIT),
    .tc(tc)
  );
  // Next state, error flag and read-data load; an ack coinciding with expiry completes cleanly
  always_comb begin
    state_nxt = state;
    err_nxt = err;
    ld = 1'b0;
    unique case (state)
      IDLE: begin
        state_nxt = req ? (miss ? DONE : ISSUE) : IDLE;
        err_nxt = req ? miss : err;
        ld = req && miss && !up_wr;
      end
      ISSUE, WAIT: begin
        state_nxt = (fin || fail) ? DONE : WAIT;
        err_nxt = (fin || fail) ? !fin : err;
        ld = (fin || fail) && !wr;
      end
      DONE: state_nxt = IDLE;
    endcase
  end
  // Access context is latched only when IDLE accepts a request; write wins over read
  always_ff @(posedge up_clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      err <= 1'b0;
      wr <= 1'b0;
      sel <= '0;
      addr <= '0;
      data <= '0;
      up_data_rd <= '0;
    end else begin
      state <= state_nxt;
      err <= err_nxt;
      if (state == IDLE && req) begin
        wr <= up_wr;
        sel <= sel_in;
        addr <= up_addr;
        data <= up_data_wr;
      end
      if (ld) up_data_rd <= err_nxt ? DEAD_VAL : rd_slice;
    end
  assign up_ack = state == DONE;
  assign up_err = up_ack & err;
  assign ch_wr = (state == ISSUE && wr) ? sel_oh : '0;
  assign ch_rd = (state == ISSUE && !wr) ? sel_oh : '0;
  assign ch_addr = addr;
  assign ch_data_wr = data;
endmodule

// File: doc/data_up_hub.md
# data_up_hub

Registered CPU-access hub between the microprocessor bus and N_CH data-path channels (tx generators, rx checkers, later ports). It decodes the channel select from `up_addr`, issues a single-cycle strobe to the selected channel, and waits for that channel's acknowledge. It returns read data, or `DEAD_VAL` on timeout or an unmapped channel. It supersedes the combinational one-bit tx/rx select in the data top level and sits between the up bus and the channel register files.

## Interface
- `N_CH`, 2: number of channels.
- `SEL_LSB`, 17: LSB of the channel-select field in `up_addr`.
- `SEL_W`, 1: width of the channel-select field.
- `TIMEOUT`, 16: cycles to wait for `ch_ack` before aborting. Legal range 2..255.
- `RD_LAT`, 1: fixed channel read latency in cycles. Used only without the macro.
- `DEAD_VAL`, 32'hDEADBEEF: read data returned on error.
- `up_clk` in 1: the only clock.
- `rst` in 1: asynchronous, active-low reset.
- `up_wr` in 1: write request, level-sampled in IDLE.
- `up_rd` in 1: read request, level-sampled in IDLE.
- `up_addr` in 32: access address.
- `up_data_wr` in 32: write data.
- `up_data_rd` out 32: registered read data.
- `up_ack` out 1: one-cycle completion pulse.
- `up_err` out 1: one-cycle error pulse, coincident with `up_ack`.
- `ch_wr` out N_CH: one-hot write strobe.
- `ch_rd` out N_CH: one-hot read strobe.
- `ch_addr` out 32: latched address.
- `ch_data_wr` out 32: latched write data.
- `ch_data_rd` in N_CH*32: channel read data. Channel i occupies bits [32i+31:32i].
- `ch_ack` in N_CH: per-channel completion.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - On `up_wr | up_rd`: latch address, data, direction and `sel = up_addr[SEL_LSB +: SEL_W]`.
  - If both requests are asserted, the write wins.
  - If `sel >= N_CH`, go to DONE with error set. Otherwise go to ISSUE.
- **ISSUE**
  - Assert `ch_wr[sel]` or `ch_rd[sel]` for exactly this cycle.
  - Clear the timeout counter to 0.
  - `ch_ack[sel]` is sampled in this state.
- **WAIT**
  - On `ch_ack[sel]`: for a read, capture the `sel` slice of `ch_data_rd`; go to DONE with no error.
  - Otherwise increment the counter. When the counter equals TIMEOUT-1 with no ack, go to DONE with error.
  - An ack that coincides with timeout expiry wins (no error).
- **DONE**
  - Pulse `up_ack`, plus `up_err` if error is set. Return to IDLE.
- `up_data_rd` update rules:
  - Updated only on read completion: captured data, or `DEAD_VAL` on error.
  - Writes leave it unchanged.
  - Holds its value until the next read completes.
- Acks from non-selected channels are ignored, in all states.
- Requests arriving while not in IDLE are ignored. The master must hold or re-issue after `up_ack`.
- `ch_addr` and `ch_data_wr` hold their latched values from ISSUE through DONE.

## Timing
- Reset values: all outputs 0, including `up_data_rd = 0`. Counter is 0, FSM is IDLE.
- Reset asserted mid-access: strobes drop immediately (asynchronously) and the FSM goes to IDLE. No `up_ack` is produced.
- Cycle numbering: request sampled in cycle 0, ISSUE in cycle 1.
- Ack timing:
  - Ack in cycle k ≥ 1 gives `up_ack` in cycle k+1.
  - Minimum `up_ack` is cycle 2.
- Timeout: `up_ack`/`up_err` in cycle TIMEOUT+1.
- Unmapped channel: `up_ack`/`up_err` in cycle 1, with no channel strobe.
- `up_data_rd` is valid in the same cycle as `up_ack`.
- The earliest next request is sampled in the cycle after `up_ack`.
- Counter width is 8 bits and never wraps, because TIMEOUT ≤ 255.

## Configuration
- Macro: `DATA_UP_HUB_ACK_EN`.
- **Defined:** ack handshake and timeout exactly as described above.
- **Undefined (legacy fixed-latency channels):**
  - `ch_ack` is ignored and the counter is reused as a latency counter.
  - Read data is captured in cycle 1+RD_LAT. `up_ack` is issued in cycle 2+RD_LAT.
  - `up_err` is asserted only for unmapped channels.

## Structure
- Shared package `data_up_pkg` holds:
  - the FSM state enum,
  - the `DEAD_VAL` default,
  - the 32-bit up data/address width constants.
- One sub-module is natural: `data_up_tmo`, an 8-bit clear/increment counter with a terminal-count flag.
- The slice mux and the decode stay inline.

## Test plan
- **Read ch1:** `N_CH=2`, read `addr=0x0402_0010`, `ch_ack[1]` in cycle 3 with data `0x1234_5678` -> `ch_rd=2'b10` in cycle 1, `up_ack` in cycle 4, `up_data_rd=0x1234_5678`, `up_err=0`.
- **Write ch0:** write `addr=0x0400_0004`, data `0xA5A5_0001`, ack in cycle 1 -> `ch_wr=2'b01` for one cycle, `ch_data_wr=0xA5A5_0001`, `up_ack` in cycle 2, `up_data_rd` unchanged.
- **Timeout:** `TIMEOUT=16`, read with no ack -> `up_ack` and `up_err` in cycle 17, `up_data_rd=0xDEADBEEF`. Repeat with ack in cycle 16 -> no error.
- **Unmapped channel:** `N_CH=3`, `SEL_W=2`, read `sel=3` -> no strobe, `up_ack`/`up_err` in cycle 1, `0xDEADBEEF`.
- **Simultaneous and stray events:** `up_wr` and `up_rd` together -> write issued. `ch_ack[0]` while `sel=1` -> ignored. A new request during WAIT -> ignored.
- **Reset mid-access:** `rst` low during WAIT -> outputs 0 and IDLE. Then, with the macro undefined and `RD_LAT=2`, a read gives `up_ack` in cycle 4.
